// File: rtl/fire_pkg.sv
// Shared constants and types for the fire-stage datapath blocks.
package fire_pkg;

  localparam int FIRE_WIDTH = 16;

  localparam int FIRE6_W_IN     = 16;
  localparam int FIRE6_H_IN     = 16;
  localparam int FIRE6_CH_TOTAL = 512;

  localparam int FIRE7_W_IN = 16;
  localparam int FIRE7_H_IN = 16;

  typedef logic [FIRE_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

endpackage

// File: rtl/ofm_hold_bank.sv
// DSP_NO-word capture register with a LANES-wide read window starting at i_rd_idx.
// While capturing, the window reads straight from the incoming vector so the
// first beat can be registered on the same edge as the capture.
module ofm_hold_bank #(
  parameter int DSP_NO = 256,
  parameter int WIDTH  = 16,
  parameter int LANES  = 8,
  parameter int CH_W   = $clog2(DSP_NO)
) (
  input  logic                   clk,
  input  logic                   i_capture,
  input  logic [WIDTH-1:0]       i_vec_data [DSP_NO],
  input  logic [CH_W-1:0]        i_rd_idx,
  output logic [LANES*WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_bank [DSP_NO];

  always_ff @(posedge clk) begin
    if (i_capture) begin
      r_bank <= i_vec_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [CH_W-1:0] w_idx;
      assign w_idx = i_rd_idx + CH_W'(gi);
      assign o_rd_data[gi*WIDTH +: WIDTH] = i_capture ? i_vec_data[w_idx] : r_bank[w_idx];
    end
  endgenerate

endmodule

// File: rtl/fire6_ofm_serializer.sv
// Captures one DSP_NO-wide ofm vector per pixel and emits it as LANES-wide
// valid/ready beats with a concat-aware word address; tracks frame completion.
module fire6_ofm_serializer
  import fire_pkg::*;
#(
  parameter int DSP_NO    = 256,
  parameter int WIDTH     = FIRE_WIDTH,
  parameter int LANES     = 8,
  parameter int W_IN      = FIRE6_W_IN,
  parameter int H_IN      = FIRE6_H_IN,
  parameter int CH_TOTAL  = FIRE6_CH_TOTAL,
  parameter int CH_OFFSET = 0,
  parameter int ADDR_W    = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   vec_valid,
  input  logic [WIDTH-1:0]       vec_data [DSP_NO],
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [LANES*WIDTH-1:0] pix_data,
  output logic [ADDR_W-1:0]      pix_addr,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overflow
);

  localparam int CH_W  = $clog2(DSP_NO);
  localparam int NPIX  = W_IN * H_IN;
  localparam int PIX_W = $clog2(NPIX) + 1;

  ser_state_t             r_state, w_state_next;
  logic [CH_W-1:0]        r_ch_cnt, w_ch_next;
  logic [PIX_W-1:0]       r_pix_cnt, w_pix_next;
  logic                   r_pix_valid, w_valid_next;
  logic                   r_frame_done, w_done_next;
  logic                   r_overflow, w_ovf_next;
  logic [LANES*WIDTH-1:0] r_pix_data;
  logic [ADDR_W-1:0]      r_pix_addr;

  logic                   w_capture;
  logic                   w_load;
  logic                   w_last;
  logic [LANES*WIDTH-1:0] w_slice;
  logic [ADDR_W-1:0]      w_addr_next;

  ofm_hold_bank #(
    .DSP_NO (DSP_NO),
    .WIDTH  (WIDTH),
    .LANES  (LANES),
    .CH_W   (CH_W)
  ) u_bank (
    .clk        (clk),
    .i_capture  (w_capture),
    .i_vec_data (vec_data),
    .i_rd_idx   (w_ch_next),
    .o_rd_data  (w_slice)
  );

  assign w_last = (r_ch_cnt == CH_W'(DSP_NO - LANES));

  // Address of the beat about to be presented, built from the post-edge counters.
  assign w_addr_next = ADDR_W'(w_pix_next) * ADDR_W'(CH_TOTAL)
                     + ADDR_W'(CH_OFFSET) + ADDR_W'(w_ch_next);

  always_comb begin
    w_state_next = r_state;
    w_ch_next    = r_ch_cnt;
    w_pix_next   = r_pix_cnt;
    w_valid_next = r_pix_valid;
    w_done_next  = r_frame_done;
    w_ovf_next   = r_overflow;
    w_capture    = 1'b0;
    w_load       = 1'b0;

    if (start) begin
      w_state_next = IDLE;
      w_ch_next    = '0;
      w_pix_next   = '0;
      w_valid_next = 1'b0;
      w_done_next  = 1'b0;
      w_ovf_next   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (vec_valid) begin
            w_capture    = 1'b1;
            w_load       = 1'b1;
            w_ch_next    = '0;
            w_valid_next = 1'b1;
            w_state_next = SHIFT;
          end
        end
        SHIFT: begin
          if (pix_ready && w_last) begin
            w_pix_next = r_pix_cnt + PIX_W'(1);
            w_ch_next  = '0;
            if (r_pix_cnt == PIX_W'(NPIX - 1)) begin
              w_state_next = DONE;
              w_valid_next = 1'b0;
              w_done_next  = 1'b1;
              if (vec_valid) w_ovf_next = 1'b1;
            end else if (vec_valid) begin
              // back-to-back: next vector starts on the very next cycle
              w_capture = 1'b1;
              w_load    = 1'b1;
            end else begin
              w_state_next = IDLE;
              w_valid_next = 1'b0;
            end
          end else begin
            if (pix_ready) begin
              w_ch_next = r_ch_cnt + CH_W'(LANES);
              w_load    = 1'b1;
            end
            if (vec_valid) w_ovf_next = 1'b1;
          end
        end
        DONE: begin
          if (vec_valid) w_ovf_next = 1'b1;
        end
        default: begin
          w_state_next = IDLE;
          w_valid_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ch_cnt     <= '0;
      r_pix_cnt    <= '0;
      r_pix_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_pix_data   <= '0;
      r_pix_addr   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_ch_cnt     <= w_ch_next;
      r_pix_cnt    <= w_pix_next;
      r_pix_valid  <= w_valid_next;
      r_frame_done <= w_done_next;
      r_overflow   <= w_ovf_next;
      if (w_load) begin
        r_pix_data <= w_slice;
        r_pix_addr <= w_addr_next;
      end
    end
  end

  assign pix_valid  = r_pix_valid;
  assign pix_data   = r_pix_data;
  assign pix_addr   = r_pix_addr;
  assign busy       = (r_state == SHIFT);
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_fire6_ofm_serializer.sv
// Self-checking bench: queue-of-expected-beats model, randomized vectors, directed scenarios.
module tb_fire6_ofm_serializer;

  localparam int DSP_NO    = 256;
  localparam int WIDTH     = 16;
  localparam int LANES     = 8;
  localparam int W_IN      = 2;
  localparam int H_IN      = 2;
  localparam int CH_TOTAL  = 512;
  localparam int CH_OFFSET = 0;
  localparam int ADDR_W    = 17;
  localparam int NPIX      = W_IN * H_IN;
  localparam int BEATS     = DSP_NO / LANES;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   start = 1'b0;
  logic                   vec_valid = 1'b0;
  logic [WIDTH-1:0]       vec [DSP_NO];
  logic                   pix_valid;
  logic                   pix_ready = 1'b0;
  logic [LANES*WIDTH-1:0] pix_data;
  logic [ADDR_W-1:0]      pix_addr;
  logic                   busy;
  logic                   frame_done;
  logic                   overflow;

  fire6_ofm_serializer #(
    .DSP_NO(DSP_NO), .WIDTH(WIDTH), .LANES(LANES), .W_IN(W_IN), .H_IN(H_IN),
    .CH_TOTAL(CH_TOTAL), .CH_OFFSET(CH_OFFSET), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_data(vec),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_addr(pix_addr), .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*WIDTH-1:0] data;
    logic [ADDR_W-1:0]      addr;
  } beat_t;

  beat_t exp_q[$];
  int    m_pixels = 0;
  bit    m_done = 1'b0;
  bit    m_ovf = 1'b0;
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_vector();
    beat_t b;
    for (int bi = 0; bi < BEATS; bi++) begin
      for (int k = 0; k < LANES; k++) b.data[k*WIDTH +: WIDTH] = vec[bi*LANES + k];
      b.addr = ADDR_W'(m_pixels * CH_TOTAL + CH_OFFSET + bi * LANES);
      exp_q.push_back(b);
    end
  endtask

  // Reference: a vector is a list of beats; a new vector is taken only when
  // nothing is pending, or exactly as the last pending beat leaves.
  task automatic model_update();
    bit was_active, last;
    if (rst || start) begin
      exp_q.delete();
      m_pixels = 0;
      m_done = 1'b0;
      m_ovf = 1'b0;
    end else begin
      was_active = (exp_q.size() != 0);
      last = 1'b0;
      if (was_active && pix_ready) begin
        void'(exp_q.pop_front());
        last = (exp_q.size() == 0);
      end
      if (!was_active) begin
        if (m_done) begin
          if (vec_valid) m_ovf = 1'b1;
        end else if (vec_valid) begin
          push_vector();
        end
      end else if (last) begin
        m_pixels++;
        if (m_pixels == NPIX) begin
          m_done = 1'b1;
          if (vec_valid) m_ovf = 1'b1;
        end else if (vec_valid) begin
          push_vector();
        end
      end else if (vec_valid) begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic step();
    bit act;
    @(posedge clk);
    cyc++;
    model_update();
    #1;
    act = (exp_q.size() != 0);
    chk("pix_valid", 128'(pix_valid), 128'(act));
    chk("busy", 128'(busy), 128'(act));
    chk("frame_done", 128'(frame_done), 128'(m_done));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    if (act) begin
      chk("pix_data", 128'(pix_data), 128'(exp_q[0].data));
      chk("pix_addr", 128'(pix_addr), 128'(exp_q[0].addr));
    end
    $display("cyc=%0d valid=%0b ready=%0b addr=%0d done=%0b ovf=%0b pending=%0d",
             cyc, pix_valid, pix_ready, pix_addr, frame_done, overflow, exp_q.size());
  endtask

  task automatic rand_vec();
    for (int i = 0; i < DSP_NO; i++) vec[i] = WIDTH'($urandom);
  endtask

  task automatic send_vec();
    rand_vec();
    vec_valid = 1'b1;
    step();
    vec_valid = 1'b0;
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1.
  // kind 1: new vector pulse when 'at' beats remain; kind 2: rst pulse then.
  task automatic run(input int mode, input int kind, input int at, input int maxc);
    bit fired = 1'b0;
    for (int c = 0; c < maxc && exp_q.size() != 0; c++) begin
      pix_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      if (!fired && kind != 0 && exp_q.size() == at && pix_ready) begin
        fired = 1'b1;
        if (kind == 1) begin
          rand_vec();
          vec_valid = 1'b1;
        end else begin
          rst = 1'b1;
        end
      end
      step();
      vec_valid = 1'b0;
      rst = 1'b0;
    end
    chk("drain_timeout", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    for (int i = 0; i < DSP_NO; i++) vec[i] = '0;

    // reset with vec_valid pulses present
    rst = 1'b1;
    vec_valid = 1'b1;
    step();
    step();
    rst = 1'b0;
    vec_valid = 1'b0;
    chk("rst_pix_data", 128'(pix_data), 128'(0));
    chk("rst_pix_addr", 128'(pix_addr), 128'(0));
    step();

    // ramp vector, then back-to-back second vector on its last beat
    for (int i = 0; i < DSP_NO; i++) vec[i] = WIDTH'(i);
    pix_ready = 1'b1;
    vec_valid = 1'b1;
    step();
    vec_valid = 1'b0;
    run(0, 1, 1, 100);
    chk("idle_busy", 128'(busy), 128'(0));

    // backpressure pixel, then final pixel of the 2x2 frame
    send_vec();
    run(1, 0, 0, 200);
    send_vec();
    run(0, 0, 0, 100);
    chk("frame_done_set", 128'(frame_done), 128'(1));

    // vector in DONE sets overflow; start (with a concurrent vec_valid) clears
    send_vec();
    start = 1'b1;
    vec_valid = 1'b1;
    step();
    start = 1'b0;
    vec_valid = 1'b0;
    chk("start_clears_ovf", 128'(overflow), 128'(0));

    // new frame: dropped vector mid-pixel under backpressure
    send_vec();
    run(1, 1, 22, 200);
    chk("drop_ovf", 128'(overflow), 128'(1));
    send_vec();
    run(0, 0, 0, 100);
    send_vec();
    run(0, 0, 0, 100);

    // reset at beat 15 of pixel 3
    send_vec();
    run(0, 2, 17, 100);
    step();
    send_vec();
    chk("post_rst_addr", 128'(pix_addr), 128'(0));
    run(0, 0, 0, 100);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fire6_ofm_serializer.md
Name: fire6_ofm_serializer

Overview:
- Sits directly downstream of the fire6 expand 1*1 stage.
- Captures the 256-wide parallel ofm vector that stage produces once per output pixel.
- Serializes the vector into LANES-wide beats with a valid/ready handshake and a concat-aware word address, feeding the fire6 concat buffer / fire7 squeeze input.
- Tracks pixels per frame and flags frame completion and dropped vectors.

Parameters:
- DSP_NO, 256, channels per captured vector (must be a multiple of LANES).
- WIDTH, 16, bits per channel word.
- LANES, 8, words emitted per output beat.
- W_IN, 16, feature map width.
- H_IN, 16, feature map height.
- CH_TOTAL, 512, channels per pixel in the concatenated map (expand1 + expand3).
- CH_OFFSET, 0, channel base of this branch in the concat (0 = expand1, 256 = expand3).
- ADDR_W, 17, word address width, equal to clog2(W_IN*H_IN*CH_TOTAL).

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset.
- start, in, 1, one-cycle pulse; clears counters and flags for a new frame.
- vec_valid, in, 1, upstream ofm vector valid (one-cycle pulse).
- vec_data, in, WIDTH x DSP_NO (unpacked array), upstream ofm vector.
- pix_valid, out, 1, output beat valid.
- pix_ready, in, 1, downstream accepts beat.
- pix_data, out, LANES*WIDTH, beat payload; lane k is at bits [k*WIDTH +: WIDTH] and holds channel ch_cnt+k.
- pix_addr, out, ADDR_W, word address of lane 0.
- busy, out, 1, high in SHIFT.
- frame_done, out, 1, all W_IN*H_IN pixels emitted.
- overflow, out, 1, sticky; a vector was dropped.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: pix_valid=0, pix_data=0, pix_addr=0, busy=0, frame_done=0, overflow=0. Internal ch_cnt=0, pix_cnt=0, state=IDLE.
- FSM IDLE:
  - vec_valid=1: latch all DSP_NO words into the holding bank, ch_cnt=0, go to SHIFT.
  - Latency: vector captured at edge N, first pix_valid=1 in the cycle after edge N.
- FSM SHIFT:
  - pix_valid=1.
  - pix_data = bank[ch_cnt .. ch_cnt+LANES-1].
  - pix_addr = pix_cnt*CH_TOTAL + CH_OFFSET + ch_cnt.
  - pix_data and pix_addr are registered and held stable while pix_ready=0.
  - Beat transfers on pix_valid && pix_ready; ch_cnt += LANES.
  - Last beat (ch_cnt == DSP_NO-LANES) transfers:
    - pix_cnt increments.
    - If pix_cnt was W_IN*H_IN-1: go to DONE.
    - Else if vec_valid in the same cycle: capture the new vector and stay in SHIFT with ch_cnt=0 (back-to-back, no bubble).
    - Else: go to IDLE.
  - vec_valid in SHIFT at any other time: vector dropped, overflow set to 1 (sticky), bank unchanged.
- FSM DONE:
  - frame_done=1, pix_valid=0.
  - vec_valid is ignored and sets overflow.
  - Stays in DONE until start.
- start: valid in any state, highest priority after rst. Forces IDLE, ch_cnt=0, pix_cnt=0, frame_done=0, overflow=0, pix_valid=0. A vec_valid in the same cycle is ignored.
- rst mid-frame: all state returns to reset values on the next edge. A partially emitted vector is discarded.
- Arithmetic:
  - pix_addr is computed unsigned in ADDR_W bits; max value W_IN*H_IN*CH_TOTAL-1 fits.
  - ch_cnt width is clog2(DSP_NO); pix_cnt width is clog2(W_IN*H_IN)+1.
- Throughput: DSP_NO/LANES = 32 cycles per vector. This is below the upstream 65-cycle vector period, so overflow occurs only under downstream backpressure.

Decomposition:
- Shared package fire_pkg:
  - WIDTH, W_IN/H_IN per fire stage.
  - CH_TOTAL for fire6 concat.
  - typedef word_t (logic [WIDTH-1:0]).
  - typedef enum ser_state_t {IDLE, SHIFT, DONE}.
- Natural sub-module: ofm_hold_bank. It is the DSP_NO-word capture register with a LANES-wide read mux indexed by ch_cnt. The FSM, counters and address generation stay in the top.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with vec_valid pulses → all outputs 0, overflow stays 0.
- Single vector, vec_data[i]=i, pix_ready=1 → 32 consecutive beats; beat 0 lanes = 0..7, pix_addr 0; beat 31 lanes = 248..255, pix_addr 248; busy low after beat 31; CH_OFFSET=256 build gives pix_addr 256..504.
- Backpressure: pix_ready toggles 1,0,0,1 → pix_data/pix_addr held during the stalls; all 32 beats delivered exactly once, in order.
- Back-to-back: second vec_valid on the last-beat cycle → no bubble, next beat has pix_addr 512 with new data. Vec_valid at beat 10 instead → dropped, overflow=1, old data completes.
- Frame end with W_IN=H_IN=2: 4 vectors → frame_done=1 after the 4th vector's last beat; a 5th vec_valid sets overflow; start clears frame_done and overflow, and the next pix_addr is 0.
- Reset mid-frame: rst at beat 15 of pixel 3 → pix_valid=0 the next cycle; a new vector then emits from pix_addr 0.
